pulpemu_clk_div_gen: RTL and testbench

- Multi-channel, runtime-programmable clock divider for the pulpemu FPGA emulation platform.
- Generates N_CH divided, flop-driven clocks from one board clock, e.g. the 32768 Hz reference clock plus extra slow clocks.
- Each channel's divisor and enable are set through a valid/ready config port.
- Divisor and enable changes take effect only at a period boundary, so outputs are glitch-free.

---
 rtl/pulpemu_clk_div_pkg.sv | 22 ++
 rtl/pulpemu_clk_div_if.sv | 27 ++
 rtl/pulpemu_clk_div_ch.sv | 98 +++++++++
 rtl/pulpemu_clk_div_gen.sv | 55 +++++
 tb/tb_pulpemu_clk_div_gen.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulpemu_clk_div_pkg.sv
// Shared types and helpers for the pulpemu multi-channel clock divider.
// Divisors travel as 32-bit values and are cut to the channel width inside each channel.
package pulpemu_clk_div_pkg;

    localparam int unsigned MIN_DIV   = 2;
    localparam int unsigned DIV_MAX_W = 32;

    typedef struct packed {
        logic                 en;
        logic [DIV_MAX_W-1:0] div;
    } cfg_t;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Anything below 2 would need a clk_i bypass, which the design never offers.
    function automatic logic [DIV_MAX_W-1:0] clamp_div(input logic [DIV_MAX_W-1:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/pulpemu_clk_div_if.sv
// Configuration port of the clock divider: one channel update per accepted beat.
// Handshake: a beat transfers on a clk_i edge where cfg_valid_i && cfg_ready_o; the master
// holds ch/div/en stable while valid is high, and ready may depend combinationally on ch.
interface pulpemu_clk_div_if
    import pulpemu_clk_div_pkg::*;
#(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned DIV_W = 16
) ();
    localparam int CH_W = ch_w(N_CH);

    logic             cfg_valid_i;
    logic             cfg_ready_o;
    logic [CH_W-1:0]  cfg_ch_i;
    logic [DIV_W-1:0] cfg_div_i;
    logic             cfg_en_i;

    modport master (
        output cfg_valid_i, cfg_ch_i, cfg_div_i, cfg_en_i,
        input  cfg_ready_o
    );

    modport slave (
        input  cfg_valid_i, cfg_ch_i, cfg_div_i, cfg_en_i,
        output cfg_ready_o
    );
endinterface

// File: rtl/pulpemu_clk_div_ch.sv
// One divider channel: period counter, active and pending settings, registered clk/tick.
// Updates land only on a wrap (or right away when stopped) so the output never glitches.
module pulpemu_clk_div_ch
    import pulpemu_clk_div_pkg::*;
#(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 256,
    parameter bit          ENABLE_RST  = 1'b1
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic load_i,
    input  cfg_t cfg_i,
    output logic clk_o,
    output logic tick_o,
    output logic busy_o
);
    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(clamp_div(DIV_MAX_W'(DEFAULT_DIV)));

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pdiv_q, pdiv_d;
    logic             en_q, en_d;
    logic             pen_q, pen_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    logic             wrap;
    logic             apply;
    logic [DIV_W-1:0] ld_div;
    logic [DIV_W-1:0] src_div;
    logic             src_en;

    assign wrap    = en_q && (cnt_q == div_q - DIV_W'(1));
    assign ld_div  = DIV_W'(clamp_div(cfg_i.div));
    // A load arriving on the wrap itself bypasses the pending register.
    assign src_div = load_i ? ld_div : pdiv_q;
    assign src_en  = load_i ? cfg_i.en : pen_q;
    assign apply   = (wrap && (load_i || pend_q)) || (!en_q && pend_q);

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        en_d   = en_q;
        pdiv_d = pdiv_q;
        pen_d  = pen_q;
        pend_d = pend_q;

        if (en_q) begin
            cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
        end else begin
            cnt_d = '0;
        end

        if (apply) begin
            div_d  = src_div;
            en_d   = src_en;
            cnt_d  = '0;
            pend_d = 1'b0;
        end else if (load_i) begin
            pdiv_d = ld_div;
            pen_d  = cfg_i.en;
            pend_d = 1'b1;
        end

        // Outputs are computed from next state so the flops track the counter they describe.
        tick_d = wrap;
        clk_d  = en_d && (cnt_d >= (div_d >> 1));
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q  <= '0;
            div_q  <= RST_DIV;
            en_q   <= ENABLE_RST;
            pdiv_q <= RST_DIV;
            pen_q  <= 1'b0;
            pend_q <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            en_q   <= en_d;
            pdiv_q <= pdiv_d;
            pen_q  <= pen_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;
    assign busy_o = pend_q;

endmodule

// File: rtl/pulpemu_clk_div_gen.sv
// Multi-channel runtime-programmable clock divider for the pulpemu emulation platform.
// Decodes config beats to channels; beats for channels that do not exist are swallowed.
module pulpemu_clk_div_gen
    import pulpemu_clk_div_pkg::*;
#(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 256,
    parameter bit          ENABLE_RST  = 1'b1
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    pulpemu_clk_div_if.slave    cfg,
    output logic [N_CH-1:0]     clk_o,
    output logic [N_CH-1:0]     tick_o,
    output logic [N_CH-1:0]     busy_o
);
    localparam int CH_W = ch_w(N_CH);

    logic            ready;
    logic [N_CH-1:0] load;
    cfg_t            cfg_req;

    always_comb begin
        ready = 1'b1;
        load  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg.cfg_ch_i == CH_W'(i)) begin
                ready   = !busy_o[i];
                load[i] = cfg.cfg_valid_i && !busy_o[i];
            end
        end
    end

    assign cfg.cfg_ready_o = ready;
    assign cfg_req.en      = cfg.cfg_en_i;
    assign cfg_req.div     = DIV_MAX_W'(cfg.cfg_div_i);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pulpemu_clk_div_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV),
            .ENABLE_RST  (ENABLE_RST)
        ) u_ch (
            .clk_i  (clk_i),
            .rstn_i (rstn_i),
            .load_i (load[g]),
            .cfg_i  (cfg_req),
            .clk_o  (clk_o[g]),
            .tick_o (tick_o[g]),
            .busy_o (busy_o[g])
        );
    end

endmodule

// File: tb/tb_pulpemu_clk_div_gen.sv
// Bench for pulpemu_clk_div_gen: reset shape, programmed periods, wrap-aligned updates,
// disable/re-enable, out-of-range channel and mid-operation reset.
module tb_pulpemu_clk_div_gen;
  import pulpemu_clk_div_pkg::*;

  localparam int unsigned N_CH  = 3;
  localparam int unsigned DIV_W = 16;
  localparam int          CH_W  = ch_w(N_CH);
  localparam int          BOUND = 1000;

  typedef struct {
    int ch;
    int div;
    bit en;
    int exp_lo;
    int exp_hi;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [N_CH-1:0] clk_o;
  logic [N_CH-1:0] tick_o;
  logic [N_CH-1:0] busy_o;

  pulpemu_clk_div_if #(.N_CH(N_CH), .DIV_W(DIV_W)) cfg_if ();

  pulpemu_clk_div_gen #(
    .N_CH(N_CH), .DIV_W(DIV_W), .DEFAULT_DIV(256), .ENABLE_RST(1'b1)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .cfg    (cfg_if),
    .clk_o  (clk_o),
    .tick_o (tick_o),
    .busy_o (busy_o)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out after %0d cycles, expected event", name, BOUND);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accepting posedge, valid dropped.
  task automatic cfg_write(input int ch, input int div, input bit en);
    int waited = 0;
    cfg_if.cfg_ch_i    = CH_W'(ch);
    cfg_if.cfg_div_i   = DIV_W'(div);
    cfg_if.cfg_en_i    = en;
    cfg_if.cfg_valid_i = 1'b1;
    #1;
    while (!cfg_if.cfg_ready_o && waited < BOUND) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= BOUND) timeout_fail("cfg_ready_wait");
    @(posedge clk);
    @(negedge clk);
    cfg_if.cfg_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int ch);
    int w = 0;
    while (busy_o[ch] && w < BOUND) begin
      @(negedge clk);
      w++;
    end
    if (w >= BOUND) timeout_fail("busy_clear");
  endtask

  task automatic wait_tick(input int ch);
    int w = 0;
    while (!tick_o[ch] && w < BOUND) begin
      @(negedge clk);
      w++;
    end
    if (w >= BOUND) timeout_fail("tick_wait");
  endtask

  // Low/high cycle counts of one period, tick to tick; all-ones on timeout.
  task automatic measure(input int ch, output logic [31:0] res);
    int w  = 0;
    int lo = 0;
    int hi = 0;
    while (!tick_o[ch] && w < BOUND) begin
      @(negedge clk);
      w++;
    end
    if (w >= BOUND) begin
      res = '1;
      return;
    end
    do begin
      if (clk_o[ch]) hi++;
      else lo++;
      @(negedge clk);
      w++;
    end while (!tick_o[ch] && w < 2 * BOUND);
    res = (w >= 2 * BOUND) ? 32'hFFFF_FFFF : {lo[15:0], hi[15:0]};
  endtask

  task automatic expect_period(input string name, input int ch, input int lo, input int hi);
    logic [31:0] got;
    exp_q.push_back({lo[15:0], hi[15:0]});
    measure(ch, got);
    check(name, got, exp_q.pop_front());
  endtask

  // Called right after rstn is released at a negedge; first sample already sees counter 1.
  task automatic post_reset_check(input string tag);
    int lo0 = 0, hi0 = 0, tk0 = 0;
    int lo1 = 0, hi1 = 0, tk1 = 0;
    for (int k = 0; k < 255; k++) begin
      @(negedge clk);
      if (clk_o[0]) hi0++; else lo0++;
      if (clk_o[1]) hi1++; else lo1++;
      tk0 += int'(tick_o[0]);
      tk1 += int'(tick_o[1]);
    end
    check({tag, "_ch0_low"},  32'(lo0), 32'd127);
    check({tag, "_ch0_high"}, 32'(hi0), 32'd128);
    check({tag, "_ch0_tick"}, 32'(tk0), 32'd0);
    check({tag, "_ch1_low"},  32'(lo1), 32'd127);
    check({tag, "_ch1_high"}, 32'(hi1), 32'd128);
    check({tag, "_ch1_tick"}, 32'(tk1), 32'd0);
    @(negedge clk);
    check({tag, "_first_tick"}, 32'(tick_o), 32'h7);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[8];

  initial begin
    logic [7:0] cseq;
    logic [7:0] tseq;
    logic [7:0] bseq;
    int         bad;
    int         w;

    vecs[0] = '{ch: 1, div: 0, en: 1'b1, exp_lo: 1, exp_hi: 1};
    vecs[1] = '{ch: 1, div: 1, en: 1'b1, exp_lo: 1, exp_hi: 1};
    vecs[2] = '{ch: 0, div: 2, en: 1'b1, exp_lo: 1, exp_hi: 1};
    vecs[3] = '{ch: 0, div: 7, en: 1'b1, exp_lo: 3, exp_hi: 4};
    vecs[4] = '{ch: 1, div: 6, en: 1'b1, exp_lo: 3, exp_hi: 3};
    vecs[5] = '{ch: 0, div: 3, en: 1'b1, exp_lo: 1, exp_hi: 2};
    vecs[6] = '{ch: 1, div: 2, en: 1'b1, exp_lo: 1, exp_hi: 1};
    vecs[7] = '{ch: 0, div: 8, en: 1'b1, exp_lo: 4, exp_hi: 4};

    cfg_if.cfg_valid_i = 1'b0;
    cfg_if.cfg_ch_i    = '0;
    cfg_if.cfg_div_i   = '0;
    cfg_if.cfg_en_i    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_clk_o",  32'(clk_o),  32'd0);
    check("rst_tick_o", 32'(tick_o), 32'd0);
    check("rst_busy_o", 32'(busy_o), 32'd0);
    check("rst_ready",  32'(cfg_if.cfg_ready_o), 32'd1);
    rstn = 1'b1;
    post_reset_check("rst1");

    // ch1 reprogrammed mid-period: held pending until the 256-cycle wrap
    cfg_write(1, 5, 1'b1);
    check("ch1_busy_pending", 32'(busy_o[1]), 32'd1);
    check("ch1_ready_low",    32'(cfg_if.cfg_ready_o), 32'd0);
    wait_idle(1);
    check("ch1_apply_tick",   32'(tick_o[1]), 32'd1);
    expect_period("ch1_div5", 1, 2, 3);
    expect_period("ch0_unaffected_256", 0, 128, 128);

    // Table of divisor updates, including clamped values 0 and 1
    for (int i = 0; i < 8; i++) begin
      cfg_write(vecs[i].ch, vecs[i].div, vecs[i].en);
      wait_idle(vecs[i].ch);
      expect_period($sformatf("vec%0d_ch%0d_div%0d", i, vecs[i].ch, vecs[i].div),
                    vecs[i].ch, vecs[i].exp_lo, vecs[i].exp_hi);
    end

    // Acceptance on the wrap cycle of ch1 (div 2): applied directly, busy never set
    w = 0;
    while (tick_o[1] && w < BOUND) begin
      @(negedge clk);
      w++;
    end
    cfg_write(1, 6, 1'b1);
    check("wrap_accept_no_busy", 32'(busy_o[1]), 32'd0);
    check("wrap_accept_tick",    32'(tick_o[1]), 32'd1);
    expect_period("wrap_accept_div6", 1, 3, 3);

    // Disable ch0 mid-period, then hold quiet
    wait_tick(0);
    cfg_write(0, 8, 1'b0);
    check("dis_busy_pending", 32'(busy_o[0]), 32'd1);
    wait_idle(0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bad += int'(clk_o[0] | tick_o[0]);
    end
    check("dis_quiet", 32'(bad), 32'd0);

    // Re-enable with div 4 on the stopped channel
    cfg_write(0, 4, 1'b1);
    check("reen_busy_pulse", 32'(busy_o[0]), 32'd1);
    cseq = '0;
    tseq = '0;
    bseq = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cseq = {cseq[6:0], clk_o[0]};
      tseq = {tseq[6:0], tick_o[0]};
      bseq = {bseq[6:0], busy_o[0]};
    end
    check("reen_clk_seq",  32'(cseq), 32'b0011_0011);
    check("reen_tick_seq", 32'(tseq), 32'b0000_1000);
    check("reen_busy_seq", 32'(bseq), 32'd0);

    // Out-of-range channel: accepted and discarded
    cfg_if.cfg_ch_i = CH_W'(3);
    #1;
    check("oor_ready", 32'(cfg_if.cfg_ready_o), 32'd1);
    cfg_write(3, 5, 1'b0);
    check("oor_no_busy", 32'(busy_o), 32'd0);
    expect_period("oor_ch0_still_div4", 0, 2, 2);
    expect_period("oor_ch1_still_div6", 1, 3, 3);

    // Reset while ch1 has a long-pending update
    cfg_write(1, 300, 1'b1);
    wait_idle(1);
    cfg_write(1, 9, 1'b1);
    check("pre_rst_busy", 32'(busy_o[1]), 32'd1);
    w = 0;
    while (!clk_o[0] && w < BOUND) begin
      @(negedge clk);
      w++;
    end
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_clk_o",  32'(clk_o),  32'd0);
    check("midrst_tick_o", 32'(tick_o), 32'd0);
    check("midrst_busy_o", 32'(busy_o), 32'd0);
    check("midrst_ready",  32'(cfg_if.cfg_ready_o), 32'd1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    post_reset_check("rst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
